// File: rtl/ahb_output_arbiter_rr.sv
// Round-robin owner select for one bus-matrix output stage.
// Holds ownership across fixed bursts, BUSY beats and locked sequences.
module ahb_output_arbiter_rr #(
  parameter int NUM_PORTS = 4
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [3:0] req_port,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [1:0] addr_in_port,
  output logic       no_port,
  output logic       burst_hold
);

  typedef enum logic [1:0] {
    T_IDLE   = 2'b00,
    T_BUSY   = 2'b01,
    T_NONSEQ = 2'b10,
    T_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] LP_LAST_RST = 2'(NUM_PORTS - 1);

  logic [1:0] r_addr;
  logic       r_nop;
  logic       r_bhold;
  logic [1:0] r_last;
  logic [3:0] r_beats;

  logic       w_sel;
  logic       w_busy;
  logic       w_hold;
  logic [3:0] w_beats_nxt;
  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_idx;

  assign w_sel  = HSELM & HTRANSM[1];
  assign w_busy = HSELM & (HTRANSM == T_BUSY);

  always_comb begin
    w_beats_nxt = '0;
    if (w_sel && HTRANSM == T_NONSEQ) begin
      unique case (HBURSTM)
        3'b010, 3'b011: w_beats_nxt = 4'd3;
        3'b100, 3'b101: w_beats_nxt = 4'd7;
        3'b110, 3'b111: w_beats_nxt = 4'd15;
        default:        w_beats_nxt = 4'd0;
      endcase
    end else if (w_sel) begin
      w_beats_nxt = (r_beats != '0) ? r_beats - 4'd1 : '0;
    end else if (w_busy) begin
      w_beats_nxt = r_beats;
    end
  end

  assign w_hold = HMASTLOCKM | (w_beats_nxt != '0) | w_busy;

  // Scan starts after the last owner, so the owner itself comes last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx = 2'((int'(r_last) + k) % NUM_PORTS);
      if (!w_found && req_port[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr  <= '0;
      r_nop   <= 1'b1;
      r_bhold <= 1'b0;
      r_last  <= LP_LAST_RST;
      r_beats <= '0;
    end else if (HREADYM) begin
      r_beats <= w_beats_nxt;
      r_bhold <= (w_beats_nxt != '0);
      if (!w_hold) begin
        if (w_found) begin
          r_addr <= w_pick;
          r_last <= w_pick;
          r_nop  <= 1'b0;
        end else begin
          r_nop  <= 1'b1;
        end
      end
    end
  end

  assign addr_in_port = r_addr;
  assign no_port      = r_nop;
  assign burst_hold   = r_bhold;

endmodule

// File: tb/tb_ahb_output_arbiter_rr.sv
// Bench for ahb_output_arbiter_rr: hand vectors, corner sequences and
// randomized traffic against a rotation-distance reference model.
module tb_ahb_output_arbiter_rr;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] req_port;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] a4, a3;
  logic       n4, n3, b4, b3;

  ahb_output_arbiter_rr #(.NUM_PORTS(4)) u4 (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM),
    .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(a4), .no_port(n4), .burst_hold(b4)
  );

  ahb_output_arbiter_rr #(.NUM_PORTS(3)) u3 (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM),
    .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(a3), .no_port(n3), .burst_hold(b3)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 models NUM_PORTS=4, index 1 models NUM_PORTS=3
  int np[2] = '{4, 3};
  int m_addr[2], m_no[2], m_last[2], m_beats[2];
  int blen[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  function automatic void model_reset(int i);
    m_addr[i]  = 0;
    m_no[i]    = 1;
    m_last[i]  = np[i] - 1;
    m_beats[i] = 0;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      int n, nb, best, bd, d;
      bit sel, busy, hold;
      n = np[i];
      if (HRESET) begin
        model_reset(i);
      end else if (HREADYM) begin
        sel  = HSELM && HTRANSM[1];
        busy = HSELM && (HTRANSM == 2'd1);
        if (sel && HTRANSM == 2'd2) nb = blen[HBURSTM] - 1;
        else if (sel) nb = (m_beats[i] > 0) ? m_beats[i] - 1 : 0;
        else if (busy) nb = m_beats[i];
        else nb = 0;
        hold = HMASTLOCKM || (nb > 0) || busy;
        m_beats[i] = nb;
        if (!hold) begin
          best = -1;
          bd = 99;
          for (int p = 0; p < n; p++) begin
            if (req_port[p]) begin
              d = (p - m_last[i] - 1 + 2 * n) % n;
              if (d < bd) begin
                bd = d;
                best = p;
              end
            end
          end
          if (best < 0) m_no[i] = 1;
          else begin
            m_addr[i] = best;
            m_last[i] = best;
            m_no[i]   = 0;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge HCLK);
    #1;
    chk("m4_addr", {2'b0, a4}, 4'(m_addr[0]));
    chk("m4_nop",  {3'b0, n4}, 4'(m_no[0]));
    chk("m4_bh",   {3'b0, b4}, {3'b0, m_beats[0] != 0});
    chk("m3_addr", {2'b0, a3}, 4'(m_addr[1]));
    chk("m3_nop",  {3'b0, n3}, 4'(m_no[1]));
    chk("m3_bh",   {3'b0, b3}, {3'b0, m_beats[1] != 0});
  endtask

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [3:0] req;
    logic       sel;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       lk;
    logic [1:0] ea;
    logic       en;
    logic       eb;
  } vec_t;

  function automatic vec_t mk(logic rst, logic rdy, logic [3:0] req,
                              logic sel, logic [1:0] tr, logic [2:0] bu,
                              logic lk, logic [1:0] ea, logic en, logic eb);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.req = req; v.sel = sel;
    v.tr = tr; v.bu = bu; v.lk = lk;
    v.ea = ea; v.en = en; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic rdy, input logic [3:0] req,
                       input logic sel, input logic [1:0] tr,
                       input logic [2:0] bu, input logic lk);
    HRESET = rst; HREADYM = rdy; req_port = req; HSELM = sel;
    HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
  endtask

  localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2, S = 2'd3;
  localparam logic [2:0] SGL = 3'd0, IN4 = 3'd3, IN8 = 3'd5, IN16 = 3'd7;

  vec_t tbl[$];

  initial begin
    model_reset(0);
    model_reset(1);
    drive(1, 1, 4'b0000, 0, I, SGL, 0);

    tbl.push_back(mk(1, 1, 4'b0000, 0, I, SGL, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 1, 4'b0000, 0, I, SGL, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'b1010, 0, I, SGL, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 4'b0000, 0, I, SGL, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 0, 3, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 0, 1, 0, 0));
    // port 2 INCR8 with BUSY and a wait state inside
    tbl.push_back(mk(0, 1, 4'b1101, 0, I, SGL, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1101, 1, N, IN8, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 4'b1101, 1, S, IN8, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 4'b1101, 1, B, IN8, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 4'b1101, 1, S, IN8, 0, 2, 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 1, 4'b1101, 1, S, IN8, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 4'b1101, 1, S, IN8, 0, 3, 0, 0));
    // port 1 locked, last burst beat coincides with lock
    tbl.push_back(mk(0, 1, 4'b0010, 0, I, SGL, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, IN4, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b1111, 1, S, IN4, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b1111, 1, S, IN4, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b1111, 1, S, IN4, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'b1111, 1, N, SGL, 0, 2, 0, 0));
    // port 0 INCR4 cut short by IDLE
    tbl.push_back(mk(0, 1, 4'b0011, 0, I, SGL, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0011, 1, N, IN4, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0011, 1, S, IN4, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0011, 1, I, IN4, 0, 1, 0, 0));
    // reset in the middle of INCR16
    tbl.push_back(mk(0, 1, 4'b0011, 1, N, IN16, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0011, 1, S, IN16, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 1, S, IN16, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, I, SGL, 0, 0, 1, 0));
    // NONSEQ during a wait state loads only once HREADYM returns
    tbl.push_back(mk(0, 1, 4'b0001, 0, I, SGL, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 1, N, IN4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0010, 1, N, IN4, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'b0000, 0, I, SGL, 0, 0, 1, 0));

    foreach (tbl[r]) begin
      vec_t v;
      v = tbl[r];
      drive(v.rst, v.rdy, v.req, v.sel, v.tr, v.bu, v.lk);
      step();
      chk($sformatf("row%0d_addr", r), {2'b0, a4}, {2'b0, v.ea});
      chk($sformatf("row%0d_nop", r),  {3'b0, n4}, {3'b0, v.en});
      chk($sformatf("row%0d_bh", r),   {3'b0, b4}, {3'b0, v.eb});
    end

    // three-port instance: port 3 request ignored, scan wraps 2 -> 0
    drive(1, 1, 4'b0000, 0, I, SGL, 0);
    step();
    drive(0, 1, 4'b1100, 0, I, SGL, 0);
    step();
    chk("np3_first", {1'b0, n3, a3}, 4'b0010);
    drive(0, 1, 4'b1100, 1, N, SGL, 0);
    step();
    chk("np3_again", {1'b0, n3, a3}, 4'b0010);
    drive(0, 1, 4'b1101, 1, N, SGL, 0);
    step();
    chk("np3_wrap", {1'b0, n3, a3}, 4'b0000);

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) == 0,
            ($urandom % 5) != 0,
            4'($urandom),
            ($urandom % 4) != 0,
            2'($urandom),
            3'($urandom),
            ($urandom % 6) == 0);
      step();
      chk("np3_range", {3'b0, a3 == 2'd3}, 4'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
